request_walker_multi: RTL and testbench

Parametrised successor to the single-request LED walker. It accepts a request and sweeps a single lit LED across an NLEDS-wide bank, advancing one position per step strobe. Supports two modes: bounce (out and back) and single pass. Adds a one-deep pending-request latch, synchronous abort, and an end-of-sweep pulse. Sits between a button/debounce front end and the board LED pins.

---
 rtl/request_walker_multi.sv | 127 ++++++++++++
 tb/tb_request_walker_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/request_walker_multi.sv
// Walks one lit LED across an NLEDS-wide bank per step strobe, bouncing or single-pass,
// with a one-deep pending request latch, synchronous abort and an end-of-sweep pulse.
module request_walker_multi #(
  parameter int NLEDS       = 6,
  parameter int STEP_CYCLES = 12_000_000,
  parameter bit OPT_PENDING = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_request,
  input  logic             i_mode,
  input  logic             i_abort,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pending
);

  localparam int CNT_W  = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int STEP_W = $clog2(2 * NLEDS);

  localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_BOUNCE = STEP_W'(2 * NLEDS - 1);
  localparam logic [STEP_W-1:0] LAST_SINGLE = STEP_W'(NLEDS);
  localparam logic [STEP_W-1:0] STEP_FIRST  = STEP_W'(1);
  localparam logic [NLEDS-1:0]  LED_ONE     = NLEDS'(1);

  logic [CNT_W-1:0]  cnt_p0;
  logic              stb_p0;
  logic [STEP_W-1:0] step_p1;
  logic [STEP_W-1:0] step_nxt;
  logic              mode_q;
  logic              mode_nxt;
  logic              pending_q;
  logic              pending_nxt;
  logic              done_q;
  logic              done_nxt;
  logic              consume;
  logic              go;
  logic [STEP_W-1:0] last_step;
  logic [NLEDS-1:0]  led_p2;

  // Out on steps 1..NLEDS, back on NLEDS+1..2*NLEDS-1; idle step 0 lights nothing.
  function automatic logic [NLEDS-1:0] led_decode(input logic [STEP_W-1:0] s);
    logic [NLEDS-1:0] r;
    r = '0;
    if (s != '0) begin
      if (s <= LAST_SINGLE) r = LED_ONE << (s - STEP_FIRST);
      else                  r = LED_ONE << (LAST_BOUNCE - s);
    end
    return r;
  endfunction

  // Stage p0: free-running step strobe, one cycle after the counter hits zero
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_p0 <= CNT_RELOAD;
      stb_p0 <= 1'b0;
    end else begin
      stb_p0 <= (cnt_p0 == '0);
      cnt_p0 <= (cnt_p0 == '0) ? CNT_RELOAD : cnt_p0 - 1'b1;
    end
  end

  assign last_step = mode_q ? LAST_SINGLE : LAST_BOUNCE;
  assign go        = pending_q | (i_request & ~OPT_PENDING);

  always_comb begin
    step_nxt    = step_p1;
    mode_nxt    = mode_q;
    pending_nxt = pending_q;
    done_nxt    = 1'b0;
    consume     = 1'b0;
    if (i_abort) begin
      step_nxt = '0;
    end else if (stb_p0) begin
      if (step_p1 == '0) begin
        if (go) begin
          step_nxt = STEP_FIRST;
          mode_nxt = i_mode;
          consume  = 1'b1;
        end
      end else if (step_p1 == last_step) begin
        done_nxt = 1'b1;
        // A waiting request chains straight into a new sweep with no idle step.
        if (pending_q) begin
          step_nxt = STEP_FIRST;
          mode_nxt = i_mode;
          consume  = 1'b1;
        end else begin
          step_nxt = '0;
        end
      end else begin
        step_nxt = step_p1 + 1'b1;
      end
    end
    if (!OPT_PENDING || i_abort || consume) pending_nxt = 1'b0;
    else if (i_request)                     pending_nxt = 1'b1;
  end

  // Stage p1: sweep position, captured mode, pending latch and done pulse
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      step_p1   <= '0;
      mode_q    <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      step_p1   <= step_nxt;
      mode_q    <= mode_nxt;
      pending_q <= pending_nxt;
      done_q    <= done_nxt;
    end
  end

  // Stage p2: registered LED decode, one cycle behind the step register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) led_p2 <= '0;
    else            led_p2 <= led_decode(step_p1);
  end

  assign o_led     = led_p2;
  assign o_busy    = (step_p1 != '0);
  assign o_done    = done_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_request_walker_multi.sv
// Directed bench for request_walker_multi with NLEDS=4, STEP_CYCLES=4, both pending options.
module tb_request_walker_multi;

  localparam int STEP = 4;
  localparam logic [31:0] BOUNCE = 32'h0124_8421;
  localparam logic [31:0] SINGLE = 32'h0000_8421;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       request;
  logic       mode;
  logic       abort;
  logic       req_np;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic       pending;
  logic [3:0] led_np;
  logic       busy_np;
  logic       done_np;
  logic       pending_np;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  request_walker_multi #(.NLEDS(4), .STEP_CYCLES(STEP), .OPT_PENDING(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_request(request), .i_mode(mode), .i_abort(abort),
    .o_led(led), .o_busy(busy), .o_done(done), .o_pending(pending)
  );

  request_walker_multi #(.NLEDS(4), .STEP_CYCLES(STEP), .OPT_PENDING(1'b0)) dut_np (
    .i_clk(clk), .i_reset_n(rst_n), .i_request(req_np), .i_mode(mode), .i_abort(abort),
    .o_led(led_np), .o_busy(busy_np), .o_done(done_np), .o_pending(pending_np)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
  endtask

  // Advance to just after the next edge on which the DUT sees its step strobe.
  task automatic wait_stb();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!((cyc % STEP == 1) && cyc >= 5) && k < 4 * STEP);
    if (k >= 4 * STEP) check("stb_bound", 32'(k), 32'(STEP));
  endtask

  task automatic pulse_request();
    request = 1'b1;
    tick();
    request = 1'b0;
  endtask

  task automatic sweep(input string tag, input int first, input int n, input logic [31:0] seq,
                       input bit chain, input int req_lo, input int req_hi, input bit flip);
    for (int i = first; i < n; i++) begin
      wait_stb();
      check($sformatf("%s_done%0d", tag, i), 32'(done), 32'(i == n - 1));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'((i < n - 1) || chain));
      if (i == n - 1) check($sformatf("%s_pend_end", tag), 32'(pending), 32'd0);
      tick();
      check($sformatf("%s_led%0d", tag, i), 32'(led),
            (i == n - 1 && chain) ? 32'd1 : ((seq >> (i * 4)) & 32'hF));
      if (i == n - 1) check($sformatf("%s_done_off", tag), 32'(done), 32'd0);
      if (i >= req_lo && i <= req_hi) begin
        pulse_request();
        check($sformatf("%s_pend%0d", tag, i), 32'(pending), 32'd1);
      end
      if (flip && i == 1) mode = !mode;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; request = 1'b0; mode = 1'b0; abort = 1'b0; req_np = 1'b0;
    tick();
    tick();
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_led_np", 32'(led_np), 32'd0);
    rst_n = 1'b1;
    cyc = 0;

    // bounce sweep from a single pulse
    pulse_request();
    check("t1_pend", 32'(pending), 32'd1);
    done_cnt = 0;
    sweep("t1", 0, 8, BOUNCE, 1'b0, -1, -1, 1'b0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // single pass
    mode = 1'b1;
    pulse_request();
    done_cnt = 0;
    sweep("t2", 0, 5, SINGLE, 1'b0, -1, -1, 1'b0);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    mode = 1'b0;

    // one request mid-sweep chains a second sweep
    pulse_request();
    done_cnt = 0;
    sweep("t3a", 0, 8, BOUNCE, 1'b1, 2, 2, 1'b0);
    sweep("t3b", 1, 8, BOUNCE, 1'b0, -1, -1, 1'b0);
    check("t3_done_cnt", 32'(done_cnt), 32'd2);

    // three requests mid-sweep still give only one extra sweep
    pulse_request();
    done_cnt = 0;
    sweep("t4a", 0, 8, BOUNCE, 1'b1, 1, 3, 1'b0);
    sweep("t4b", 1, 8, BOUNCE, 1'b0, -1, -1, 1'b0);
    wait_stb();
    wait_stb();
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd2);

    // abort at step 3 with a pending request
    pulse_request();
    done_cnt = 0;
    wait_stb();
    wait_stb();
    wait_stb();
    tick();
    check("t5_led_s3", 32'(led), 32'd4);
    pulse_request();
    check("t5_pend", 32'(pending), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_pend_clr", 32'(pending), 32'd0);
    check("t5_led_lag", 32'(led), 32'd4);
    tick();
    check("t5_led_off", 32'(led), 32'd0);
    wait_stb();
    wait_stb();
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_no_done", 32'(done_cnt), 32'd0);

    // abort wins over a same-cycle request
    abort = 1'b1;
    request = 1'b1;
    tick();
    abort = 1'b0;
    request = 1'b0;
    check("t6_pend", 32'(pending), 32'd0);
    wait_stb();
    wait_stb();
    check("t6_idle", 32'(busy), 32'd0);

    // mode toggled mid-sweep leaves the bounce sequence intact
    pulse_request();
    sweep("t7", 0, 8, BOUNCE, 1'b0, -1, -1, 1'b1);
    mode = 1'b0;

    // reset mid-sweep clears outputs and restarts the strobe phase
    pulse_request();
    wait_stb();
    wait_stb();
    wait_stb();
    rst_n = 1'b0;
    tick();
    check("t8_led", 32'(led), 32'd0);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_done", 32'(done), 32'd0);
    check("t8_pend", 32'(pending), 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    pulse_request();
    tick();
    tick();
    tick();
    check("t8_pre_stb", 32'(busy), 32'd0);
    tick();
    check("t8_first_stb", 32'(busy), 32'd1);
    tick();
    check("t8_led0", 32'(led), 32'd1);
    sweep("t8", 1, 8, BOUNCE, 1'b0, -1, -1, 1'b0);

    // no pending latch: start only on a strobe, requests while busy ignored
    req_np = 1'b1;
    wait_stb();
    req_np = 1'b0;
    check("t9_start", 32'(busy_np), 32'd1);
    for (int i = 1; i < 8; i++) begin
      if (i >= 2 && i <= 4) begin
        req_np = 1'b1;
        tick();
        req_np = 1'b0;
        check($sformatf("t9_pend%0d", i), 32'(pending_np), 32'd0);
      end
      wait_stb();
      check($sformatf("t9_busy%0d", i), 32'(busy_np), 32'(i < 7));
      check($sformatf("t9_done%0d", i), 32'(done_np), 32'(i == 7));
    end
    wait_stb();
    wait_stb();
    check("t9_no_second", 32'(busy_np), 32'd0);
    check("t9_led_off", 32'(led_np), 32'd0);
    req_np = 1'b1;
    tick();
    req_np = 1'b0;
    wait_stb();
    check("t9_offstb_req", 32'(busy_np), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
